// File: rtl/keypad_digit_entry.sv
// rtl/keypad_digit_entry.sv - debounced one-digit-per-press keypad entry with BCD shift buffer
// Optional feature: define KEYPAD_ROLLOVER_EN to keep shifting when the buffer is full.
module keypad_digit_entry #(
  parameter int NUM_DIGITS      = 4,
  parameter int DEBOUNCE_CYCLES = 8,
  localparam int CW             = $clog2(NUM_DIGITS + 1),
  localparam int DW             = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [9:0]              keypad,
  input  logic                    enablen,
  input  logic                    clear,
  output logic [3:0]              bcd,
  output logic                    loadn,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [CW-1:0]           digit_count,
  output logic                    full
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  localparam logic [DW-1:0] CNT_ONE = DW'(1);
  localparam logic [DW-1:0] CNT_MAX = DW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_DIGITS);

  logic [9:0]              sync1_q, ks_q;
  logic [1:0]              state_q, state_d;
  logic [9:0]              cand_q, cand_d;
  logic [DW-1:0]           cnt_q, cnt_d;
  logic [3:0]              bcd_q, bcd_d;
  logic                    loadn_q, loadn_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d, digits_shifted;
  logic [CW-1:0]           count_q, count_d;
  logic                    accept;
  logic                    ks_valid;

  function automatic logic [3:0] encode(input logic [9:0] k);
    logic [3:0] r;
    r = 4'hF;
    for (int i = 0; i < 10; i++) begin
      if (k[i]) r = 4'(i);
    end
    return r;
  endfunction

  assign ks_valid = (ks_q != 10'd0) && ((ks_q & (ks_q - 10'd1)) == 10'd0);

  generate
    if (NUM_DIGITS == 1) begin : g_shift_one
      assign digits_shifted = encode(ks_q);
    end else begin : g_shift_many
      assign digits_shifted = {digits_q[4*NUM_DIGITS-5:0], encode(ks_q)};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    accept  = 1'b0;
    if (enablen) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      bcd_d   = 4'hF;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ks_valid) begin
            cand_d = ks_q;
            if (CNT_ONE == CNT_MAX) begin
              accept  = 1'b1;
              state_d = S_HELD;
              cnt_d   = '0;
            end else begin
              state_d = S_DEBOUNCE;
              cnt_d   = CNT_ONE;
            end
          end
        end
        S_DEBOUNCE: begin
          if (ks_q == cand_q) begin
            if (cnt_q + CNT_ONE == CNT_MAX) begin
              accept  = 1'b1;
              state_d = S_HELD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end
        S_HELD: begin
          if (ks_q == 10'd0) begin
            if (CNT_ONE == CNT_MAX) begin
              state_d = S_IDLE;
              cnt_d   = '0;
              bcd_d   = 4'hF;
            end else begin
              state_d = S_RELEASE;
              cnt_d   = CNT_ONE;
            end
          end
        end
        default: begin
          if (ks_q == 10'd0) begin
            if (cnt_q + CNT_ONE == CNT_MAX) begin
              state_d = S_IDLE;
              cnt_d   = '0;
              bcd_d   = 4'hF;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            state_d = S_HELD;
            cnt_d   = '0;
          end
        end
      endcase
      // accept only occurs when ks equals the candidate, so ks encodes the digit
      if (accept) bcd_d = encode(ks_q);
    end
  end

  always_comb begin
    digits_d = digits_q;
    count_d  = count_q;
    loadn_d  = 1'b1;
    if (clear) begin
      digits_d = '0;
      count_d  = '0;
    end else if (accept) begin
      loadn_d = 1'b0;
      if (count_q != CNT_FULL) begin
        digits_d = digits_shifted;
        count_d  = count_q + CW'(1);
      end else begin
`ifdef KEYPAD_ROLLOVER_EN
        digits_d = digits_shifted;
`else
        digits_d = digits_q;
`endif
      end
    end
  end

  // Synchroniser is held empty while disabled so a held key is re-sampled from scratch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      ks_q    <= '0;
    end else if (enablen) begin
      sync1_q <= '0;
      ks_q    <= '0;
    end else begin
      sync1_q <= keypad;
      ks_q    <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      cnt_q    <= '0;
      bcd_q    <= 4'hF;
      loadn_q  <= 1'b1;
      digits_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      loadn_q  <= loadn_d;
      digits_q <= digits_d;
      count_q  <= count_d;
    end
  end

  assign bcd         = bcd_q;
  assign loadn       = loadn_q;
  assign digits      = digits_q;
  assign digit_count = count_q;
  assign full        = (count_q == CNT_FULL);

endmodule

// File: tb/tb_keypad_digit_entry.sv
// tb/tb_keypad_digit_entry.sv - scoreboard bench for keypad_digit_entry (NUM_DIGITS=4, DEBOUNCE_CYCLES=4)
module tb_keypad_digit_entry;

  typedef struct {
    logic [3:0]  d;
    logic [15:0] digits;
    logic [2:0]  cnt;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enablen = 1'b0;
  logic        clear = 1'b0;
  logic [9:0]  keypad = '0;
  logic [3:0]  bcd;
  logic        loadn;
  logic [15:0] digits;
  logic [2:0]  digit_count;
  logic        full;

  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [15:0] m_digits = '0;
  int          m_count = 0;

  keypad_digit_entry #(.NUM_DIGITS(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .keypad(keypad), .enablen(enablen), .clear(clear),
    .bcd(bcd), .loadn(loadn), .digits(digits), .digit_count(digit_count), .full(full)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_accept(input int d, input int ec);
    exp_t e;
    if (m_count < 4) begin
      m_digits = {m_digits[11:0], 4'(d)};
      m_count++;
    end else begin
`ifdef KEYPAD_ROLLOVER_EN
      m_digits = {m_digits[11:0], 4'(d)};
`endif
    end
    e.d = 4'(d);
    e.digits = m_digits;
    e.cnt = 3'(m_count);
    e.cyc = ec;
    exp_q.push_back(e);
  endtask

  task automatic press_release(input int key);
    keypad = 10'(1) << key;
    expect_accept(key, cyc + 6);
    tick(10);
    keypad = '0;
    tick(10);
  endtask

  always @(negedge clk) begin
    if (!rst && loadn === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_loadn: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("acc_bcd", 32'(bcd), 32'(e.d));
        chk("acc_digits", 32'(digits), 32'(e.digits));
        chk("acc_count", 32'(digit_count), 32'(e.cnt));
        if (e.cyc >= 0) chk("acc_latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_bcd", 32'(bcd), 32'hF);
    chk("rst_loadn", 32'(loadn), 32'd1);
    chk("rst_digits", 32'(digits), 32'd0);
    chk("rst_count", 32'(digit_count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    rst = 1'b0;
    tick(2);

    // key 5 held 20 cycles
    keypad = 10'b0000100000;
    expect_accept(5, cyc + 6);
    tick(20);
    keypad = '0;
    tick(10);
    chk("key5_digits", 32'(digits), 32'h0005);
    chk("key5_count", 32'(digit_count), 32'd1);

    // bounce on key 3
    for (int i = 0; i < 3; i++) begin
      keypad = 10'b0000001000;
      tick(2);
      keypad = '0;
      tick(2);
    end
    tick(10);
    chk("bounce_digits", 32'(digits), 32'h0005);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    m_digits = '0;
    m_count = 0;
    chk("clear_digits", 32'(digits), 32'd0);

    press_release(1);
    press_release(2);
    press_release(0);
    press_release(9);
    chk("four_digits", 32'(digits), 32'h1209);
    chk("four_full", 32'(full), 32'd1);
    press_release(7);
`ifdef KEYPAD_ROLLOVER_EN
    chk("full_digits", 32'(digits), 32'h2097);
`else
    chk("full_digits", 32'(digits), 32'h1209);
`endif
    chk("full_count", 32'(digit_count), 32'd4);

    // two keys at once
    keypad = 10'b0000000110;
    tick(20);
    chk("multi_bcd", 32'(bcd), 32'hF);
    keypad = '0;
    tick(10);

    // enablen pulse mid-debounce
    keypad = 10'b0000010000;
    tick(3);
    enablen = 1'b1;
    tick(3);
    chk("en_digits_kept", 32'(digits), 32'(m_digits));
    chk("en_bcd", 32'(bcd), 32'hF);
    enablen = 1'b0;
    expect_accept(4, cyc + 6);
    tick(14);
    keypad = '0;
    tick(10);

    // clear coincides with accept of key 8
    keypad = 10'b0100000000;
    tick(5);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    m_digits = '0;
    m_count = 0;
    tick(5);
    chk("clracc_digits", 32'(digits), 32'd0);
    chk("clracc_count", 32'(digit_count), 32'd0);
    keypad = '0;
    tick(10);

    // key 6 accepted, then reset while held
    keypad = 10'b0001000000;
    expect_accept(6, cyc + 6);
    tick(12);
    chk("key6_digits", 32'(digits), 32'h0006);
    rst = 1'b1;
    #1;
    chk("held_rst_bcd", 32'(bcd), 32'hF);
    chk("held_rst_loadn", 32'(loadn), 32'd1);
    chk("held_rst_digits", 32'(digits), 32'd0);
    chk("held_rst_count", 32'(digit_count), 32'd0);
    chk("held_rst_full", 32'(full), 32'd0);
    m_digits = '0;
    m_count = 0;
    tick(2);
    rst = 1'b0;
    expect_accept(6, cyc + 6);
    tick(12);
    keypad = '0;
    tick(10);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick(1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
